// File: rtl/rk_pkg.sv
// Shared types and field layout for the RK parameter loader.
// The word stream is a flat image: a (row-major), b, c, k, x0, y0, h0.
package rk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int A_BASE = 0;

    function automatic int rk_total_words(input int s);
        return s * s + 3 * s + 3;
    endfunction

    function automatic int rk_b_base(input int s);
        return s * s;
    endfunction

    function automatic int rk_c_base(input int s);
        return s * s + s;
    endfunction

    function automatic int rk_k_base(input int s);
        return s * s + 2 * s;
    endfunction

    function automatic int rk_x0_off(input int s);
        return s * s + 3 * s;
    endfunction

endpackage

// File: rtl/rk_param_loader.sv
// Streaming loader that assembles a narrow word stream into the parallel
// Butcher-tableau and initial-condition arrays of the RK register stage.
module rk_param_loader
    import rk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 3
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [WIDTH-1:0] o_a [S*S],
    output logic signed [WIDTH-1:0] o_b [S],
    output logic signed [WIDTH-1:0] o_c [S],
    output logic signed [WIDTH-1:0] o_k [S],
    output logic signed [WIDTH-1:0] o_x0,
    output logic signed [WIDTH-1:0] o_y0,
    output logic signed [WIDTH-1:0] o_h0,
    output state_t                  o_state
);

    localparam int TOTAL  = rk_total_words(S);
    localparam int IDX_W  = $clog2(TOTAL);
    localparam int B_BASE = rk_b_base(S);
    localparam int C_BASE = rk_c_base(S);
    localparam int K_BASE = rk_k_base(S);
    localparam int X0_OFF = rk_x0_off(S);
    localparam int Y0_OFF = X0_OFF + 1;
    localparam int H0_OFF = X0_OFF + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [S*S-1:0]   wr_a;
    logic [S-1:0]     wr_b;
    logic [S-1:0]     wr_c;
    logic [S-1:0]     wr_k;
    logic             wr_x0;
    logic             wr_y0;
    logic             wr_h0;

    // Handshake: a word transfers on a clk edge where i_valid && o_ready;
    // o_ready comes from registered state only, and a word alongside i_load is dropped.
    assign accept  = (state == LOAD) && i_valid && !i_load;
    assign o_state = state;

    always_comb begin
        wr_a  = '0;
        wr_b  = '0;
        wr_c  = '0;
        wr_k  = '0;
        wr_x0 = 1'b0;
        wr_y0 = 1'b0;
        wr_h0 = 1'b0;
        for (int i = 0; i < S * S; i++) begin
            wr_a[i] = accept && (idx == IDX_W'(A_BASE + i));
        end
        for (int i = 0; i < S; i++) begin
            wr_b[i] = accept && (idx == IDX_W'(B_BASE + i));
            wr_c[i] = accept && (idx == IDX_W'(C_BASE + i));
            wr_k[i] = accept && (idx == IDX_W'(K_BASE + i));
        end
        wr_x0 = accept && (idx == IDX_W'(X0_OFF));
        wr_y0 = accept && (idx == IDX_W'(Y0_OFF));
        wr_h0 = accept && (idx == IDX_W'(H0_OFF));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            idx     <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_load) begin
                        state   <= LOAD;
                        idx     <= '0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_load) begin
                        idx <= '0;
                    end else if (accept) begin
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            idx     <= '0;
                            o_ready <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

    // Arrays are cleared only by reset; a new load overwrites element by element.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < S * S; i++) o_a[i] <= '0;
            for (int i = 0; i < S; i++) begin
                o_b[i] <= '0;
                o_c[i] <= '0;
                o_k[i] <= '0;
            end
            o_x0 <= '0;
            o_y0 <= '0;
            o_h0 <= '0;
        end else begin
            for (int i = 0; i < S * S; i++) begin
                if (wr_a[i]) o_a[i] <= i_data;
            end
            for (int i = 0; i < S; i++) begin
                if (wr_b[i]) o_b[i] <= i_data;
                if (wr_c[i]) o_c[i] <= i_data;
                if (wr_k[i]) o_k[i] <= i_data;
            end
            if (wr_x0) o_x0 <= i_data;
            if (wr_y0) o_y0 <= i_data;
            if (wr_h0) o_h0 <= i_data;
        end
    end

endmodule

// File: tb/tb_rk_param_loader.sv
// Directed and randomized bench for rk_param_loader against a flat-image
// reference model of the coefficient stream (S=3, 21 words).
module tb_rk_param_loader;
    import rk_pkg::*;

    localparam int WIDTH = 32;
    localparam int S     = 3;
    localparam int TOTAL = S * S + 3 * S + 3;

    logic                    clk;
    logic                    i_rst;
    logic                    i_load;
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_data;
    logic                    o_ready;
    logic                    o_busy;
    logic                    o_done;
    logic signed [WIDTH-1:0] o_a [S*S];
    logic signed [WIDTH-1:0] o_b [S];
    logic signed [WIDTH-1:0] o_c [S];
    logic signed [WIDTH-1:0] o_k [S];
    logic signed [WIDTH-1:0] o_x0;
    logic signed [WIDTH-1:0] o_y0;
    logic signed [WIDTH-1:0] o_h0;
    state_t                  o_state;

    rk_param_loader #(.WIDTH(WIDTH), .S(S)) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_load  (i_load),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_c     (o_c),
        .o_k     (o_k),
        .o_x0    (o_x0),
        .o_y0    (o_y0),
        .o_h0    (o_h0),
        .o_state (o_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: parameter image in stream order plus load progress.
    logic [WIDTH-1:0] img [TOTAL];
    int               pos;
    bit               m_loading;
    bit               m_done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_seen = 0;
    int done_cyc  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TOTAL; i++) img[i] = '0;
        pos       = 0;
        m_loading = 1'b0;
        m_done    = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input bit ld, input bit vld, input logic [31:0] d);
        if (rst) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_loading) begin
            if (ld) begin
                pos = 0;
            end else if (vld) begin
                img[pos] = d;
                pos++;
                if (pos == TOTAL) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                    pos       = 0;
                end
            end
        end else if (ld) begin
            m_loading = 1'b1;
            pos       = 0;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_state;
        exp_state = m_loading ? 32'(LOAD) : (m_done ? 32'(DONE) : 32'(IDLE));
        chk("ready", 32'(o_ready), 32'(m_loading));
        chk("busy", 32'(o_busy), 32'(m_loading || m_done));
        chk("done", 32'(o_done), 32'(m_done));
        chk("state", 32'(o_state), exp_state);
        for (int i = 0; i < S * S; i++) chk($sformatf("a[%0d]", i), o_a[i], img[i]);
        for (int i = 0; i < S; i++) begin
            chk($sformatf("b[%0d]", i), o_b[i], img[S*S + i]);
            chk($sformatf("c[%0d]", i), o_c[i], img[S*S + S + i]);
            chk($sformatf("k[%0d]", i), o_k[i], img[S*S + 2*S + i]);
        end
        chk("x0", o_x0, img[S*S + 3*S]);
        chk("y0", o_y0, img[S*S + 3*S + 1]);
        chk("h0", o_h0, img[S*S + 3*S + 2]);
    endtask

    // Driver: check this cycle's outputs, drive inputs, advance one edge.
    task automatic step(input bit rst, input bit ld, input bit vld, input logic [31:0] d);
        check_all();
        if (o_done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        i_rst   = rst;
        i_load  = ld;
        i_valid = vld;
        i_data  = d;
        @(posedge clk);
        model_edge(rst, ld, vld, d);
        cyc++;
        @(negedge clk);
        i_rst   = 1'b0;
        i_load  = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic start_phase();
        cyc       = 0;
        done_seen = 0;
        done_cyc  = -1;
    endtask

    initial begin
        int guard;
        logic [31:0] next;
        i_rst   = 1'b1;
        i_load  = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        i_rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_h0", o_h0, 32'd0);

        // Clean full-rate load of 1..21
        start_phase();
        step(0, 1, 0, 0);
        for (int i = 1; i <= TOTAL; i++) step(0, 0, 1, 32'(i));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s1_done_cycle", 32'(done_cyc), 32'd22);
        chk("s1_done_count", 32'(done_seen), 32'd1);
        chk("s1_a0", o_a[0], 32'd1);
        chk("s1_a8", o_a[8], 32'd9);
        chk("s1_b0", o_b[0], 32'd10);
        chk("s1_c2", o_c[2], 32'd15);
        chk("s1_k2", o_k[2], 32'd18);
        chk("s1_x0", o_x0, 32'd19);
        chk("s1_y0", o_y0, 32'd20);
        chk("s1_h0", o_h0, 32'd21);

        // Half-rate load after reset
        step(1, 0, 0, 0);
        start_phase();
        step(0, 1, 0, 0);
        next = 1;
        for (int c = 1; c <= 41; c++) begin
            if (c % 2 == 1) begin
                step(0, 0, 1, next);
                next++;
            end else begin
                step(0, 0, 0, $urandom);
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s2_done_cycle", 32'(done_cyc), 32'd42);
        chk("s2_a4", o_a[4], 32'd5);
        chk("s2_h0", o_h0, 32'd21);

        // Restart mid-load
        start_phase();
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'(100 + i));
        step(0, 1, 1, 32'd999);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 32'(200 + i));
        step(0, 0, 0, 0);
        chk("s3_no_early_done", 32'(done_seen), 32'd0);
        step(0, 0, 1, 32'd220);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s3_done_count", 32'(done_seen), 32'd1);
        chk("s3_a0", o_a[0], 32'd200);
        chk("s3_h0", o_h0, 32'd220);

        // Reset after 10 accepts, then stray valid words without load
        start_phase();
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom);
        step(1, 0, 1, $urandom);
        chk("s4_a0_cleared", o_a[0], 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom);
        chk("s4_no_done", 32'(done_seen), 32'd0);
        chk("s4_a1", o_a[1], 32'd0);

        // Valid held in IDLE
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h7FFF_FFFF);
        chk("s5_ready", 32'(o_ready), 32'd0);
        chk("s5_x0", o_x0, 32'd0);

        // All -1 then all 0
        step(0, 1, 0, 0);
        for (int i = 0; i < TOTAL; i++) step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s6_b1_neg", o_b[1], 32'hFFFF_FFFF);
        chk("s6_a8_neg", o_a[8], 32'hFFFF_FFFF);
        step(0, 1, 0, 0);
        for (int i = 0; i < TOTAL; i++) step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s6_a4_zero", o_a[4], 32'd0);
        chk("s6_h0_zero", o_h0, 32'd0);

        // Randomized loads: gaps, stray restarts, load pulses during DONE
        for (int n = 0; n < 6; n++) begin
            step(0, 1, $urandom_range(0, 1), $urandom);
            guard = 0;
            while (m_loading && guard < 300) begin
                step(0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom);
                guard++;
            end
            chk("rnd_bounded", 32'(m_loading), 32'd0);
            step(0, $urandom_range(0, 1), 1, $urandom);
            step(0, 0, $urandom_range(0, 1), $urandom);
        end
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
